// File: rtl/ysyx_22040750_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one owner at a time.
// Define YSYX_22040750_ARB_RR_EN for round-robin arbitration; default is fixed LSU priority.
module ysyx_22040750_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        I_sys_clk,
  input  logic        I_rst_n,
  input  logic        I_if_valid,
  input  logic [31:0] I_if_addr,
  output logic        O_if_ready,
  output logic        O_if_resp_valid,
  output logic [31:0] O_if_rdata,
  input  logic        I_ls_valid,
  input  logic [31:0] I_ls_addr,
  input  logic        I_ls_wen,
  input  logic [63:0] I_ls_wdata,
  input  logic [7:0]  I_ls_wstrb,
  output logic        O_ls_ready,
  output logic        O_ls_resp_valid,
  output logic [63:0] O_ls_rdata,
  input  logic        I_fencei,
  output logic        O_mem_valid,
  input  logic        I_mem_ready,
  output logic [31:0] O_mem_addr,
  output logic        O_mem_wen,
  output logic [63:0] O_mem_wdata,
  output logic [7:0]  O_mem_wstrb,
  input  logic        I_mem_resp_valid,
  input  logic [63:0] I_mem_rdata,
  output logic        O_busy,
  output logic        O_timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IF_REQ  = 3'd1,
    S_IF_RESP = 3'd2,
    S_LS_REQ  = 3'd3,
    S_LS_RESP = 3'd4
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYC[7:0];

  state_e     state_q, state_d;
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic [7:0] wd_inc_s;
  logic       timeout_q, timeout_d;
  logic       if_req_s, grant_ls_s, grant_if_s;

  assign wd_inc_s = (wd_cnt_q == 8'hFF) ? 8'hFF : wd_cnt_q + 8'd1;

`ifdef YSYX_22040750_ARB_RR_EN
  logic last_ls_q, last_ls_d;

  // Last-owner tracking: a tie goes to whoever did not win the previous grant.
  always_comb begin
    last_ls_d = last_ls_q;
    if (state_q == S_IDLE && (grant_ls_s || grant_if_s)) begin
      last_ls_d = grant_ls_s;
    end else begin
      last_ls_d = last_ls_q;
    end
  end

  // Last-owner register, reset to IF so the first tie goes to the LSU.
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      last_ls_q <= 1'b0;
    end else begin
      last_ls_q <= last_ls_d;
    end
  end
`endif

  // Grant selection; fence.i only masks new instruction fetches.
  always_comb begin
    if_req_s = I_if_valid & ~I_fencei;
`ifdef YSYX_22040750_ARB_RR_EN
    grant_ls_s = I_ls_valid & ~(if_req_s & last_ls_q);
`else
    grant_ls_s = I_ls_valid;
`endif
    grant_if_s = if_req_s & ~grant_ls_s;
  end

  // Next-state logic and response watchdog.
  always_comb begin
    state_d   = state_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ls_s) begin
          state_d = S_LS_REQ;
        end else if (grant_if_s) begin
          state_d = S_IF_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IF_REQ, S_LS_REQ: begin
        if (I_mem_ready) begin
          state_d  = (state_q == S_IF_REQ) ? S_IF_RESP : S_LS_RESP;
          wd_cnt_d = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_IF_RESP, S_LS_RESP: begin
        if (I_mem_resp_valid) begin
          state_d = S_IDLE;
        end else begin
          // The FSM keeps waiting after a timeout; the flag is only a report.
          wd_cnt_d = wd_inc_s;
          if (wd_inc_s >= TIMEOUT_LIM) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output mux; everything is forced low while reset is asserted.
  always_comb begin
    O_mem_valid     = 1'b0;
    O_mem_addr      = 32'd0;
    O_mem_wen       = 1'b0;
    O_mem_wdata     = 64'd0;
    O_mem_wstrb     = 8'd0;
    O_if_ready      = 1'b0;
    O_if_resp_valid = 1'b0;
    O_if_rdata      = 32'd0;
    O_ls_ready      = 1'b0;
    O_ls_resp_valid = 1'b0;
    O_ls_rdata      = 64'd0;
    O_busy          = 1'b0;
    O_timeout       = 1'b0;
    if (I_rst_n) begin
      case (state_q)
        S_IF_REQ: begin
          O_mem_valid = 1'b1;
          O_mem_addr  = I_if_addr;
          O_if_ready  = I_mem_ready;
        end
        S_LS_REQ: begin
          O_mem_valid = 1'b1;
          O_mem_addr  = I_ls_addr;
          O_mem_wen   = I_ls_wen;
          O_mem_wdata = I_ls_wdata;
          O_mem_wstrb = I_ls_wstrb;
          O_ls_ready  = I_mem_ready;
        end
        S_IF_RESP: begin
          O_if_resp_valid = I_mem_resp_valid;
          O_if_rdata      = I_mem_rdata[31:0];
        end
        S_LS_RESP: begin
          O_ls_resp_valid = I_mem_resp_valid;
          O_ls_rdata      = I_mem_rdata;
        end
        default: begin
          O_mem_valid = 1'b0;
        end
      endcase
      O_busy    = (state_q != S_IDLE);
      O_timeout = timeout_q;
    end else begin
      O_busy = 1'b0;
    end
  end

  // State, watchdog counter and sticky timeout flag.
  always_ff @(posedge I_sys_clk) begin
    if (!I_rst_n) begin
      state_q   <= S_IDLE;
      wd_cnt_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_mem_arbiter.sv
// Randomized and directed bench for the IF/LSU memory arbiter against a transaction-level model.
module tb_ysyx_22040750_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, ls_valid, ls_wen, fencei, mem_ready, mem_resp_valid;
  logic [31:0] if_addr, ls_addr;
  logic [63:0] ls_wdata, mem_rdata;
  logic [7:0]  ls_wstrb;
  logic        if_ready, if_resp_valid, ls_ready, ls_resp_valid;
  logic [31:0] if_rdata, mem_addr;
  logic [63:0] ls_rdata, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_valid, mem_wen, busy, timeout;

  always #5 clk = ~clk;

  ysyx_22040750_mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .I_sys_clk(clk), .I_rst_n(rst_n),
    .I_if_valid(if_valid), .I_if_addr(if_addr), .O_if_ready(if_ready),
    .O_if_resp_valid(if_resp_valid), .O_if_rdata(if_rdata),
    .I_ls_valid(ls_valid), .I_ls_addr(ls_addr), .I_ls_wen(ls_wen),
    .I_ls_wdata(ls_wdata), .I_ls_wstrb(ls_wstrb), .O_ls_ready(ls_ready),
    .O_ls_resp_valid(ls_resp_valid), .O_ls_rdata(ls_rdata),
    .I_fencei(fencei), .O_mem_valid(mem_valid), .I_mem_ready(mem_ready),
    .O_mem_addr(mem_addr), .O_mem_wen(mem_wen), .O_mem_wdata(mem_wdata),
    .O_mem_wstrb(mem_wstrb), .I_mem_resp_valid(mem_resp_valid),
    .I_mem_rdata(mem_rdata), .O_busy(busy), .O_timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the current transaction as a record.
  bit          m_act, m_ls, m_acc, m_to, m_last_ls;
  int          m_wait;
  logic [31:0] m_addr;
  bit          m_wen;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;

  // Agent controls and observation counters.
  bit          rnd_req, stray_en, rd_rand, hs_if, hs_ls;
  int          resp_cnt, lat_lo, lat_hi, ready_pct, ready_hold;
  logic [63:0] rd_fixed;
  int          n_if_ready, n_ls_ready, n_if_resp, n_mv;
  logic        last_to, last_if_resp;

  task automatic check_outputs();
    logic        e_mv, e_ifr, e_lsr, e_ifv, e_lsv, e_wen, e_busy, e_to;
    logic [31:0] e_addr, e_ifd;
    logic [63:0] e_wdata, e_lsd;
    logic [7:0]  e_wstrb;
    e_mv = 0; e_ifr = 0; e_lsr = 0; e_ifv = 0; e_lsv = 0; e_wen = 0; e_busy = 0;
    e_addr = 32'd0; e_ifd = 32'd0; e_wdata = 64'd0; e_lsd = 64'd0; e_wstrb = 8'd0;
    e_to = rst_n && m_to;
    if (rst_n && m_act) begin
      e_busy = 1;
      if (!m_acc) begin
        e_mv = 1; e_addr = m_addr; e_wen = m_wen; e_wdata = m_wdata; e_wstrb = m_wstrb;
        if (m_ls) e_lsr = mem_ready; else e_ifr = mem_ready;
      end else if (m_ls) begin
        e_lsv = mem_resp_valid; e_lsd = mem_rdata;
      end else begin
        e_ifv = mem_resp_valid; e_ifd = mem_rdata[31:0];
      end
    end
    check_val("mem_valid", 64'(mem_valid), 64'(e_mv));
    check_val("mem_addr", 64'(mem_addr), 64'(e_addr));
    check_val("mem_wen", 64'(mem_wen), 64'(e_wen));
    check_val("mem_wdata", mem_wdata, e_wdata);
    check_val("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
    check_val("if_ready", 64'(if_ready), 64'(e_ifr));
    check_val("ls_ready", 64'(ls_ready), 64'(e_lsr));
    check_val("if_resp_valid", 64'(if_resp_valid), 64'(e_ifv));
    check_val("ls_resp_valid", 64'(ls_resp_valid), 64'(e_lsv));
    check_val("if_rdata", 64'(if_rdata), 64'(e_ifd));
    check_val("ls_rdata", ls_rdata, e_lsd);
    check_val("busy", 64'(busy), 64'(e_busy));
    check_val("timeout", 64'(timeout), 64'(e_to));
  endtask

  task automatic model_update();
    bit want_if, pick_ls;
    if (!rst_n) begin
      m_act = 0; m_acc = 0; m_to = 0; m_wait = 0; m_last_ls = 0;
    end else if (!m_act) begin
      want_if = if_valid && !fencei;
`ifdef YSYX_22040750_ARB_RR_EN
      pick_ls = ls_valid && !(want_if && m_last_ls);
`else
      pick_ls = ls_valid;
`endif
      if (ls_valid || want_if) begin
        m_act = 1; m_acc = 0; m_ls = pick_ls; m_last_ls = pick_ls;
        m_addr  = pick_ls ? ls_addr : if_addr;
        m_wen   = pick_ls ? ls_wen : 1'b0;
        m_wdata = pick_ls ? ls_wdata : 64'd0;
        m_wstrb = pick_ls ? ls_wstrb : 8'd0;
      end
    end else if (!m_acc) begin
      if (mem_ready) begin m_acc = 1; m_wait = 0; end
    end else if (mem_resp_valid) begin
      m_act = 0;
    end else begin
      if (m_wait < 255) m_wait++;
      if (m_wait >= int'(TO)) m_to = 1;
    end
  endtask

  task automatic drive_agents();
    if (hs_if) if_valid = 0;
    if (hs_ls) ls_valid = 0;
    if (rnd_req) begin
      if (!if_valid && $urandom_range(0, 2) == 0) begin
        if_valid = 1; if_addr = $urandom;
      end
      if (!ls_valid && $urandom_range(0, 2) == 0) begin
        ls_valid = 1; ls_addr = $urandom; ls_wen = 1'($urandom_range(0, 1));
        ls_wdata = {$urandom, $urandom}; ls_wstrb = 8'($urandom);
      end
      fencei = ($urandom_range(0, 4) == 0);
    end
    if (!rst_n) resp_cnt = 0;
    mem_resp_valid = 0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        mem_resp_valid = 1;
        mem_rdata = rd_rand ? {$urandom, $urandom} : rd_fixed;
      end
    end else if (stray_en) begin
      mem_resp_valid = ($urandom_range(0, 7) == 0);
      mem_rdata = {$urandom, $urandom};
    end
    if (ready_hold > 0 && mem_valid) begin
      ready_hold--; mem_ready = 0;
    end else begin
      mem_ready = (ready_pct >= int'($urandom_range(1, 100)));
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    hs_if = if_ready; hs_ls = ls_ready;
    n_if_ready += int'(if_ready); n_ls_ready += int'(ls_ready);
    n_if_resp += int'(if_resp_valid); n_mv += int'(mem_valid);
    last_to = timeout; last_if_resp = if_resp_valid;
    if (rst_n && mem_valid && mem_ready) resp_cnt = $urandom_range(lat_lo, lat_hi);
    @(posedge clk);
    model_update();
    #1;
    drive_agents();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clear_counts();
    n_if_ready = 0; n_ls_ready = 0; n_if_resp = 0; n_mv = 0;
  endtask

  initial begin
    rst_n = 0; if_valid = 0; ls_valid = 0; ls_wen = 0; fencei = 0;
    mem_ready = 0; mem_resp_valid = 0; if_addr = 0; ls_addr = 0;
    ls_wdata = 0; ls_wstrb = 0; mem_rdata = 0;
    rnd_req = 0; stray_en = 0; rd_rand = 0; rd_fixed = 64'd0; hs_if = 0; hs_ls = 0;
    resp_cnt = 0; lat_lo = 1; lat_hi = 1; ready_pct = 100; ready_hold = 0;
    m_act = 0; m_acc = 0; m_ls = 0; m_to = 0; m_last_ls = 0; m_wait = 0;
    m_addr = 0; m_wen = 0; m_wdata = 0; m_wstrb = 0;
    clear_counts();
    run(2);
    rst_n = 1;
    run(2);

    // Single fetch: ready immediately, response two cycles after accept.
    lat_lo = 2; lat_hi = 2; rd_fixed = 64'h0000_0000_0000_0013;
    clear_counts();
    if_valid = 1; if_addr = 32'h3000_0000;
    run(7);
    check_val("fetch_ready_pulses", 64'(n_if_ready), 64'd1);
    check_val("fetch_resp_count", 64'(n_if_resp), 64'd1);

    // Simultaneous IF + LSU write.
    lat_lo = 1; lat_hi = 1; rd_fixed = 64'h1122_3344_5566_7788;
    if_valid = 1; if_addr = 32'h3000_0004;
    ls_valid = 1; ls_addr = 32'h8000_0008; ls_wen = 1;
    ls_wdata = 64'h0000_0000_DEAD_BEEF; ls_wstrb = 8'h0F;
    run(9);
    check_val("pair_both_served", 64'({if_valid, ls_valid}), 64'd0);

    // fence.i holds off fetch but not LSU.
    clear_counts();
    fencei = 1; if_valid = 1; if_addr = 32'h3000_0008;
    run(10);
    check_val("fencei_no_grant", 64'(n_mv), 64'd0);
    ls_valid = 1; ls_addr = 32'h8000_0010; ls_wen = 0;
    run(5);
    check_val("fencei_ls_served", 64'(n_ls_ready), 64'd1);
    fencei = 0;
    run(5);
    check_val("fencei_if_served", 64'(n_if_ready), 64'd1);

    // Memory stalls five cycles in LS_REQ.
    clear_counts();
    ready_hold = 5;
    ls_valid = 1; ls_addr = 32'h8000_0020; ls_wen = 0;
    run(10);
    check_val("stall_ls_ready_pulses", 64'(n_ls_ready), 64'd1);

    // Randomized traffic with stray responses.
    rnd_req = 1; stray_en = 1; rd_rand = 1; ready_pct = 60; lat_lo = 1; lat_hi = 3;
    run(2000);
    rnd_req = 0; stray_en = 0; fencei = 0;
    run(25);
    check_val("random_drained", 64'({if_valid, ls_valid, busy}), 64'd0);

    // Watchdog: no response after accept.
    ready_pct = 100; lat_lo = 1000; lat_hi = 1000; rd_rand = 0;
    if_valid = 1; if_addr = 32'h3000_0100;
    run(8);
    check_val("timeout_set", 64'(last_to), 64'd1);
    resp_cnt = 1;
    run(3);
    check_val("timeout_sticky", 64'(last_to), 64'd1);
    rst_n = 0;
    run(1);
    rst_n = 1;
    run(1);
    check_val("timeout_cleared", 64'(last_to), 64'd0);

    // Reset in IF_RESP, then a stray response.
    if_valid = 1; if_addr = 32'h3000_0200;
    run(3);
    rst_n = 0;
    run(1);
    rst_n = 1;
    mem_resp_valid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    run(1);
    check_val("stray_after_reset", 64'(last_if_resp), 64'd0);
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
